// File: rtl/cpu_pkg.sv
// Shared CPU pipeline constants: MDU latencies, Tuse/Tnew encodings, MDU timer states.
package cpu_pkg;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;
  localparam int CNT_W    = 4;

  localparam logic [1:0] TUSE_NONE   = 2'd3;
  localparam logic [1:0] TNEW_READY  = 2'd0;
  localparam logic [1:0] TNEW_E_ALU  = 2'd1;
  localparam logic [1:0] TNEW_E_LOAD = 2'd2;
  localparam logic [1:0] TNEW_M_LOAD = 2'd1;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } md_state_e;

endpackage

// File: rtl/hazard_md_ctrl_md_timer.sv
// MDU occupancy timer: loads the op latency on md_go and counts down to a one-cycle md_done.
module md_timer #(
  parameter int MULT_LAT = 5,
  parameter int DIV_LAT  = 10,
  parameter int CNT_W    = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic md_go,
  input  logic e_md_div,
  output logic md_busy,
  output logic md_done
);
  import cpu_pkg::*;

  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  md_state_e        state_r, next_state_s;
  logic [CNT_W-1:0] cnt_r, next_cnt_s;
  logic             busy_r, done_r, next_busy_s, next_done_s;

  // State, counter and registered flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r <= IDLE;
      cnt_r   <= CNT_ZERO;
      busy_r  <= 1'b0;
      done_r  <= 1'b0;
    end else begin
      state_r <= next_state_s;
      cnt_r   <= next_cnt_s;
      busy_r  <= next_busy_s;
      done_r  <= next_done_s;
    end
  end

  // Next state and count; a start while BUSY cannot reach here because md_go is gated on IDLE
  always_comb begin
    next_state_s = state_r;
    next_cnt_s   = cnt_r;
    case (state_r)
      IDLE: begin
        if (md_go) begin
          next_state_s = BUSY;
          next_cnt_s   = e_md_div ? CNT_W'(DIV_LAT) : CNT_W'(MULT_LAT);
        end else begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
        end
      end
      BUSY: begin
        if (cnt_r == CNT_ONE) begin
          next_state_s = IDLE;
          next_cnt_s   = CNT_ZERO;
        end else begin
          next_state_s = BUSY;
          next_cnt_s   = cnt_r - CNT_ONE;
        end
      end
      default: begin
        next_state_s = IDLE;
        next_cnt_s   = CNT_ZERO;
      end
    endcase
  end

  // Flags for the coming cycle, so the outputs come straight from flops
  always_comb begin
    next_busy_s = (next_state_s == BUSY);
    next_done_s = (next_state_s == BUSY) && (next_cnt_s == CNT_ONE);
  end

  assign md_busy = busy_r;
  assign md_done = done_r;

endmodule

// File: rtl/hazard_md_ctrl.sv
// Pipeline stall controller: D-stage data/MDU hazards, flush priority and MDU start gating.
module hazard_md_ctrl #(
  parameter int MULT_LAT = cpu_pkg::MULT_LAT,
  parameter int DIV_LAT  = cpu_pkg::DIV_LAT,
  parameter int CNT_W    = cpu_pkg::CNT_W
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       Req,
  input  logic [4:0] d_rs_addr,
  input  logic [4:0] d_rt_addr,
  input  logic [1:0] d_tuse_rs,
  input  logic [1:0] d_tuse_rt,
  input  logic       d_is_md,
  input  logic [4:0] e_wa,
  input  logic [1:0] e_tnew,
  input  logic [4:0] m_wa,
  input  logic [1:0] m_tnew,
  input  logic       e_md_start,
  input  logic       e_md_div,
  output logic       stall,
  output logic       f_we,
  output logic       d_we,
  output logic       md_go,
  output logic       md_busy,
  output logic       md_done
);

  logic haz_rs_s, haz_rt_s, haz_md_s, stall_s, md_go_s;

  // Hazard decision; Tuse of 3 never exceeds a Tnew (max 2) so unused operands drop out
  always_comb begin
    haz_rs_s = (d_rs_addr != 5'd0) &&
               (((e_wa == d_rs_addr) && (d_tuse_rs < e_tnew)) ||
                ((m_wa == d_rs_addr) && (d_tuse_rs < m_tnew)));
    haz_rt_s = (d_rt_addr != 5'd0) &&
               (((e_wa == d_rt_addr) && (d_tuse_rt < e_tnew)) ||
                ((m_wa == d_rt_addr) && (d_tuse_rt < m_tnew)));
    haz_md_s = d_is_md && (md_busy || e_md_start);
    stall_s  = (haz_rs_s || haz_rt_s || haz_md_s) && !Req;
    md_go_s  = e_md_start && !md_busy && !Req;
  end

  assign stall = stall_s;
  assign f_we  = !stall_s;
  assign d_we  = !stall_s;
  assign md_go = md_go_s;

  md_timer #(
    .MULT_LAT (MULT_LAT),
    .DIV_LAT  (DIV_LAT),
    .CNT_W    (CNT_W)
  ) u_md_timer (
    .clk      (clk),
    .reset    (reset),
    .md_go    (md_go_s),
    .e_md_div (e_md_div),
    .md_busy  (md_busy),
    .md_done  (md_done)
  );

endmodule

// File: tb/tb_hazard_md_ctrl.sv
// Self-checking bench for hazard_md_ctrl: directed scenarios plus random traffic against a reference model.
module tb_hazard_md_ctrl;

  localparam int MULT_LAT = 5;
  localparam int DIV_LAT  = 10;

  logic       clk = 1'b0;
  logic       reset;
  logic       Req;
  logic [4:0] d_rs_addr, d_rt_addr, e_wa, m_wa;
  logic [1:0] d_tuse_rs, d_tuse_rt, e_tnew, m_tnew;
  logic       d_is_md, e_md_start, e_md_div;
  logic       stall, f_we, d_we, md_go, md_busy, md_done;

  int n_tests = 0;
  int n_fail  = 0;
  // Reference model: MDU is busy for cycles bstart..bend (inclusive), cycle = posedges seen
  int cyc    = 0;
  int bstart = 0;
  int bend   = -1;
  logic go_m;

  hazard_md_ctrl #(.MULT_LAT(MULT_LAT), .DIV_LAT(DIV_LAT), .CNT_W(4)) dut (
    .clk(clk), .reset(reset), .Req(Req),
    .d_rs_addr(d_rs_addr), .d_rt_addr(d_rt_addr),
    .d_tuse_rs(d_tuse_rs), .d_tuse_rt(d_tuse_rt), .d_is_md(d_is_md),
    .e_wa(e_wa), .e_tnew(e_tnew), .m_wa(m_wa), .m_tnew(m_tnew),
    .e_md_start(e_md_start), .e_md_div(e_md_div),
    .stall(stall), .f_we(f_we), .d_we(d_we),
    .md_go(md_go), .md_busy(md_busy), .md_done(md_done)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic clear_in();
    Req = 1'b0; d_rs_addr = 5'd0; d_rt_addr = 5'd0;
    d_tuse_rs = 2'd3; d_tuse_rt = 2'd3; d_is_md = 1'b0;
    e_wa = 5'd0; e_tnew = 2'd0; m_wa = 5'd0; m_tnew = 2'd0;
    e_md_start = 1'b0; e_md_div = 1'b0;
  endtask

  function automatic logic model_busy();
    return (cyc >= bstart) && (cyc <= bend);
  endfunction

  // Compare all outputs against the model, then advance one clock and return at the negedge
  task automatic check_cycle();
    logic busy_m, hrs, hrt, hmd, stall_m;
    #1;
    busy_m  = model_busy();
    hrs     = (d_rs_addr != 0) && ((e_wa == d_rs_addr && d_tuse_rs < e_tnew) ||
                                   (m_wa == d_rs_addr && d_tuse_rs < m_tnew));
    hrt     = (d_rt_addr != 0) && ((e_wa == d_rt_addr && d_tuse_rt < e_tnew) ||
                                   (m_wa == d_rt_addr && d_tuse_rt < m_tnew));
    hmd     = d_is_md && (busy_m || e_md_start);
    stall_m = (hrs || hrt || hmd) && !Req;
    go_m    = e_md_start && !busy_m && !Req;
    check_eq("m_stall", stall, stall_m);
    check_eq("m_f_we", f_we, !stall_m);
    check_eq("m_d_we", d_we, !stall_m);
    check_eq("m_md_go", md_go, go_m);
    check_eq("m_md_busy", md_busy, busy_m);
    check_eq("m_md_done", md_done, busy_m && (cyc == bend));
    @(posedge clk);
    cyc++;
    if (go_m) begin
      bstart = cyc;
      bend   = cyc + (e_md_div ? DIV_LAT : MULT_LAT) - 1;
    end
    @(negedge clk);
  endtask

  // Start an MDU op at k=0 with d_is_md held high; checks busy/done/stall timeline
  task automatic md_timeline(input logic div, input string tag);
    int lat;
    lat = div ? DIV_LAT : MULT_LAT;
    for (int k = 0; k <= lat + 1; k++) begin
      clear_in();
      d_is_md = 1'b1;
      e_md_start = (k == 0);
      e_md_div = div;
      #1;
      check_eq({tag, "_stall"}, stall, (k <= lat));
      check_eq({tag, "_busy"}, md_busy, (k >= 1 && k <= lat));
      check_eq({tag, "_done"}, md_done, (k == lat));
      if (k == 0) check_eq({tag, "_go"}, md_go, 1'b1);
      check_cycle();
    end
  endtask

  initial begin
    int busy_cnt;
    clear_in();
    reset = 1'b0;
    #2;
    check_eq("rst_stall", stall, 1'b0);
    check_eq("rst_f_we", f_we, 1'b1);
    check_eq("rst_d_we", d_we, 1'b1);
    check_eq("rst_go", md_go, 1'b0);
    check_eq("rst_busy", md_busy, 1'b0);
    check_eq("rst_done", md_done, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // Load-use, then the same producer at M with Tnew 1 against Tuse 1
    clear_in(); e_wa = 5'd8; e_tnew = 2'd2; d_rs_addr = 5'd8; d_tuse_rs = 2'd0;
    #1; check_eq("lu_stall", stall, 1'b1); check_eq("lu_f_we", f_we, 1'b0);
    check_cycle();
    clear_in(); m_wa = 5'd8; m_tnew = 2'd1; d_rs_addr = 5'd8; d_tuse_rs = 2'd1;
    #1; check_eq("lu_next_stall", stall, 1'b0);
    check_cycle();

    // $0 never hazards; an unused rt never hazards
    clear_in(); e_wa = 5'd0; d_rs_addr = 5'd0; e_tnew = 2'd2; d_tuse_rs = 2'd0;
    #1; check_eq("zero_reg", stall, 1'b0);
    check_cycle();
    clear_in(); m_wa = 5'd9; m_tnew = 2'd2; d_rt_addr = 5'd9; d_tuse_rt = 2'd3;
    #1; check_eq("tuse_none", stall, 1'b0);
    check_cycle();

    md_timeline(1'b0, "mult");
    md_timeline(1'b1, "div");

    // Flush priority
    clear_in(); Req = 1'b1; e_md_start = 1'b1;
    #1; check_eq("flush_go", md_go, 1'b0);
    check_cycle();
    clear_in();
    #1; check_eq("flush_nobusy", md_busy, 1'b0);
    check_cycle();
    clear_in(); Req = 1'b1; e_wa = 5'd3; e_tnew = 2'd2; d_rt_addr = 5'd3; d_tuse_rt = 2'd0;
    #1; check_eq("flush_stall", stall, 1'b0);
    check_cycle();
    for (int k = 0; k <= MULT_LAT + 1; k++) begin
      clear_in(); e_md_start = (k == 0); Req = (k >= 2 && k <= 4);
      #1; check_eq("req_busy_done", md_done, (k == MULT_LAT));
      check_cycle();
    end

    // Asynchronous reset mid-div, with the counter at 6
    clear_in(); e_md_start = 1'b1; e_md_div = 1'b1;
    check_cycle();
    for (int k = 1; k <= 4; k++) begin
      clear_in();
      check_cycle();
    end
    #1; check_eq("pre_rst_busy", md_busy, 1'b1);
    #1; reset = 1'b0;
    #1; check_eq("arst_busy", md_busy, 1'b0);
    check_eq("arst_done", md_done, 1'b0);
    bend = -1;
    @(posedge clk); cyc++;
    #1; check_eq("arst_done_hold", md_done, 1'b0);
    @(negedge clk); reset = 1'b1;
    busy_cnt = 0;
    for (int k = 0; k < MULT_LAT + 3; k++) begin
      clear_in(); e_md_start = (k == 0);
      #1; if (md_busy) busy_cnt++;
      check_cycle();
    end
    check_eq("post_rst_mult_len", busy_cnt, MULT_LAT);

    // Random traffic over a small register range so hazards are frequent
    for (int i = 0; i < 400; i++) begin
      Req        = ($urandom_range(0, 7) == 0);
      d_rs_addr  = 5'($urandom_range(0, 3));
      d_rt_addr  = 5'($urandom_range(0, 3));
      d_tuse_rs  = 2'($urandom_range(0, 3));
      d_tuse_rt  = 2'($urandom_range(0, 3));
      d_is_md    = ($urandom_range(0, 3) == 0);
      e_wa       = 5'($urandom_range(0, 3));
      e_tnew     = 2'($urandom_range(0, 2));
      m_wa       = 5'($urandom_range(0, 3));
      m_tnew     = 2'($urandom_range(0, 1));
      e_md_start = !model_busy() && ($urandom_range(0, 5) == 0);
      e_md_div   = 1'($urandom_range(0, 1));
      check_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
